// File: rtl/ceespu_intc.sv
// ceespu_intc: four-source interrupt controller for the ceespu decode stage.
//
// Ports
//   I_clk         system clock, all state on the rising edge
//   I_rst         synchronous active-high reset
//   I_irq[3:0]    external interrupt sources, bit n is source n
//   I_int_ack     one-cycle acknowledge from the decode stage
//   I_memE        register-bus access enable
//   I_memWe       register-bus write strobe (qualified by I_memE)
//   I_addr[1:0]   register select: 0 PENDING (W1C), 1 ENABLE, 2 STATUS, 3 SOFT (write-1-to-set)
//   I_wdata[31:0] register-bus write data
//   O_rdata[31:0] registered read data
//   O_int         interrupt request to the decode stage
//   O_int_vector  index of the requested source, valid while O_int=1
//
// Build option
//   CEESPU_INTC_EDGE_EN  defined: each source goes through a 2-flop synchronizer
//                        and a rising edge at its output sets pending.
//                        undefined: sources are level-sensitive and unsynchronized.
module ceespu_intc (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [3:0]  I_irq,
  input  logic        I_int_ack,
  input  logic        I_memE,
  input  logic        I_memWe,
  input  logic [1:0]  I_addr,
  input  logic [31:0] I_wdata,
  output logic [31:0] O_rdata,
  output logic        O_int,
  output logic [1:0]  O_int_vector
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned VW   = 2;
  localparam int unsigned DW   = 32;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SOFT    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] irq_event;
  logic [NSRC-1:0] pend_en;
  logic [NSRC-1:0] set_mask;
  logic [NSRC-1:0] clr_mask;
  logic            any_req;
  logic [VW-1:0]   winner;
  logic            int_nxt;
  logic [VW-1:0]   vec_nxt;
  logic            ack_clr;
  logic            wr_en;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            wdata_unused;

  assign wr_en        = I_memE & I_memWe;
  assign rd_en        = I_memE & ~I_memWe;
  assign wdata_unused = ^I_wdata[DW-1:NSRC];

`ifdef CEESPU_INTC_EDGE_EN
  // Two-flop synchronizer plus one history stage; a 0->1 at the synchronizer output is the event.
  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;
  logic [NSRC-1:0] sync_prev;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= I_irq;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign irq_event = sync2 & ~sync_prev;
`else
  // Level mode: a high source re-sets pending every cycle it stays high.
  assign irq_event = I_irq;
`endif

  // Fixed priority: lowest enabled pending index wins.
  assign pend_en = pending & enable;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_en[i]) begin
        winner  = VW'(i);
        any_req = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; ack only matters in REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req)   state_nxt = ST_REQ;
      ST_REQ:  if (I_int_ack) state_nxt = ST_GAP;
      ST_GAP:                 state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered request outputs and the ack clear.
  always_comb begin
    int_nxt = O_int;
    vec_nxt = O_int_vector;
    ack_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          int_nxt = 1'b1;
          vec_nxt = winner;
        end
      end
      ST_REQ: begin
        if (I_int_ack) begin
          int_nxt = 1'b0;
          ack_clr = 1'b1;
        end
      end
      default: int_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_int        <= 1'b0;
      O_int_vector <= '0;
    end else begin
      O_int        <= int_nxt;
      O_int_vector <= vec_nxt;
    end
  end

  // Pending set/clear masks; set wins over clear on the same bit.
  always_comb begin
    set_mask = irq_event;
    clr_mask = '0;
    if (wr_en && (I_addr == ADDR_SOFT))    set_mask = set_mask | I_wdata[NSRC-1:0];
    if (wr_en && (I_addr == ADDR_PENDING)) clr_mask = I_wdata[NSRC-1:0];
    if (ack_clr)                           clr_mask = clr_mask | (NSRC'(1) << O_int_vector);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      enable <= '0;
    end else if (wr_en && (I_addr == ADDR_ENABLE)) begin
      enable <= I_wdata[NSRC-1:0];
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_data = '0;
    case (I_addr)
      ADDR_PENDING: rd_data = DW'(pending);
      ADDR_ENABLE:  rd_data = DW'(enable);
      ADDR_STATUS:  rd_data = DW'({O_int_vector, state});
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_rdata <= '0;
    end else if (rd_en) begin
      O_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_ceespu_intc.sv
module tb_ceespu_intc;

  logic        I_clk;
  logic        I_rst;
  logic [3:0]  I_irq;
  logic        I_int_ack;
  logic        I_memE;
  logic        I_memWe;
  logic [1:0]  I_addr;
  logic [31:0] I_wdata;
  logic [31:0] O_rdata;
  logic        O_int;
  logic [1:0]  O_int_vector;

  int total = 0;
  int bad   = 0;

  ceespu_intc dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_irq       (I_irq),
    .I_int_ack   (I_int_ack),
    .I_memE      (I_memE),
    .I_memWe     (I_memWe),
    .I_addr      (I_addr),
    .I_wdata     (I_wdata),
    .O_rdata     (O_rdata),
    .O_int       (O_int),
    .O_int_vector(O_int_vector)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Reference model: 0 idle, 1 requesting, 2 gap.
  int          m_state;
  logic [3:0]  m_pend;
  logic [3:0]  m_en;
  logic [1:0]  m_vec;
  logic [31:0] m_rdata;
`ifdef CEESPU_INTC_EDGE_EN
  // m_hist[i] = I_irq sampled i+1 edges ago.
  logic [3:0]  m_hist [3];
`endif

  task automatic model_step();
    logic [3:0] ev;
    logic [3:0] setm;
    logic [3:0] clrm;
    int         win;
    bit         wr;
    if (I_rst) begin
      m_state = 0;
      m_pend  = 4'h0;
      m_en    = 4'h0;
      m_vec   = 2'd0;
      m_rdata = 32'h0;
`ifdef CEESPU_INTC_EDGE_EN
      for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
`endif
      return;
    end
    if (I_memE && !I_memWe) begin
      case (I_addr)
        2'd0:    m_rdata = {28'h0, m_pend};
        2'd1:    m_rdata = {28'h0, m_en};
        2'd2:    m_rdata = {26'h0, m_vec, 2'(m_state)};
        default: m_rdata = 32'h0;
      endcase
    end
`ifdef CEESPU_INTC_EDGE_EN
    ev = m_hist[1] & ~m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = I_irq;
`else
    ev = I_irq;
`endif
    wr   = I_memE && I_memWe;
    setm = ev | ((wr && I_addr == 2'd3) ? I_wdata[3:0] : 4'h0);
    clrm = (wr && I_addr == 2'd0) ? I_wdata[3:0] : 4'h0;
    win  = -1;
    for (int n = 0; n < 4; n++)
      if (m_pend[n] && m_en[n] && win < 0) win = n;
    case (m_state)
      0: if (win >= 0) begin m_state = 1; m_vec = 2'(win); end
      1: if (I_int_ack) begin clrm[m_vec] = 1'b1; m_state = 2; end
      default: m_state = 0;
    endcase
    m_pend = (m_pend & ~clrm) | setm;
    if (wr && I_addr == 2'd1) m_en = I_wdata[3:0];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("O_int",        32'(O_int),        32'(m_state == 1));
    chk("O_int_vector", 32'(O_int_vector), 32'(m_vec));
    chk("O_rdata",      O_rdata,           m_rdata);
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge I_clk);
    model_step();
    @(negedge I_clk);
    compare();
  endtask

  task automatic bus_idle();
    I_memE    = 1'b0;
    I_memWe   = 1'b0;
    I_addr    = 2'd0;
    I_wdata   = 32'h0;
    I_int_ack = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    I_memE = 1'b1; I_memWe = 1'b1; I_addr = a; I_wdata = d;
    cycle();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a);
    I_memE = 1'b1; I_memWe = 1'b0; I_addr = a;
    cycle();
    bus_idle();
  endtask

  task automatic wait_int(input int budget);
    for (int i = 0; i < budget && !O_int; i++) cycle();
    chk("wait_int", 32'(O_int), 32'd1);
  endtask

  task automatic do_ack();
    I_int_ack = 1'b1;
    cycle();
    I_int_ack = 1'b0;
  endtask

  int  cnt;
  bit  prev_int;

  initial begin
    I_irq = 4'h0;
    bus_idle();
    I_rst = 1'b1;
    cycle();
    cycle();
    chk("reset O_int", 32'(O_int), 32'd0);
    chk("reset O_rdata", O_rdata, 32'd0);
    I_rst = 1'b0;

    // Single source, vector 2, ack, gap, pending empty.
    bus_write(2'd1, 32'h6);
    I_irq = 4'b0100;
    cycle();
    I_irq = 4'h0;
    wait_int(8);
    chk("vec2", 32'(O_int_vector), 32'd2);
    bus_read(2'd2);
    chk("status in REQ", O_rdata, 32'h9);
    do_ack();
    chk("gap O_int", 32'(O_int), 32'd0);
    bus_read(2'd0);
    chk("pending after ack", O_rdata, 32'h0);

    // Simultaneous sources 3 and 1: 1 first, then 3.
    bus_write(2'd1, 32'hF);
    I_irq = 4'b1010;
    cycle();
    I_irq = 4'h0;
    wait_int(8);
    chk("vec1 first", 32'(O_int_vector), 32'd1);
    do_ack();
    wait_int(8);
    chk("vec3 second", 32'(O_int_vector), 32'd3);
    do_ack();
    cycle();

    // Higher-priority arrival during REQ does not disturb the vector.
    bus_write(2'd3, 32'h4);
    wait_int(8);
    chk("vec2 soft", 32'(O_int_vector), 32'd2);
    I_irq = 4'b0001;
    cycle();
    I_irq = 4'h0;
    for (int i = 0; i < 5; i++) cycle();
    chk("held O_int", 32'(O_int), 32'd1);
    chk("held vec", 32'(O_int_vector), 32'd2);
    do_ack();
    wait_int(8);
    chk("vec0 after gap", 32'(O_int_vector), 32'd0);
    do_ack();
    cycle();

    // SOFT set, then W1C colliding with a source-3 event.
    bus_write(2'd1, 32'h8);
    bus_write(2'd3, 32'h8);
    wait_int(8);
    chk("soft vec3", 32'(O_int_vector), 32'd3);
    do_ack();
    cycle();
    bus_write(2'd1, 32'h0);
    I_irq = 4'b1000;
`ifdef CEESPU_INTC_EDGE_EN
    cycle();
    cycle();
`endif
    bus_write(2'd0, 32'h8);
    I_irq = 4'h0;
    bus_read(2'd0);
    chk("set beats clear", O_rdata, 32'h8);
    bus_write(2'd0, 32'hF);

    // Reset while requesting.
    bus_write(2'd1, 32'h8);
    bus_write(2'd3, 32'h8);
    wait_int(8);
    I_rst = 1'b1;
    cycle();
    chk("rst drops O_int", 32'(O_int), 32'd0);
    I_rst = 1'b0;
    bus_read(2'd2);
    chk("status after rst", O_rdata, 32'h0);
    bus_read(2'd0);
    chk("pending after rst", O_rdata, 32'h0);

    // Source 0 held high for 10 cycles, acking every request.
    bus_write(2'd1, 32'h1);
    I_irq    = 4'b0001;
    cnt      = 0;
    prev_int = 1'b0;
    for (int i = 0; i < 10; i++) begin
      I_int_ack = O_int;
      cycle();
      if (O_int && !prev_int) cnt++;
      prev_int = O_int;
    end
    I_irq = 4'h0;
`ifdef CEESPU_INTC_EDGE_EN
    chk("held level one request", 32'(cnt), 32'd1);
`else
    chk("held level re-requests", 32'(cnt >= 2), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      I_int_ack = O_int;
      cycle();
    end
    bus_idle();
    bus_write(2'd0, 32'hF);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      I_rst     = ($urandom_range(63) == 0);
      I_memE    = 1'($urandom_range(1));
      I_memWe   = 1'($urandom_range(1));
      I_addr    = 2'($urandom_range(3));
      I_wdata   = $urandom;
      I_irq     = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
      I_int_ack = O_int ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
